// File: rtl/mmio_pkg.sv
// Shared constants for the data-bus responder: address map, STATUS bit
// positions, default FIFO depth and a word-address compare helper.
package mmio_pkg;

    localparam logic [31:0] RAM_LIMIT   = 32'h0000_0100;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_0400;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0404;
    localparam logic [31:0] ADDR_CYCLES = 32'h0000_0408;

    localparam int STAT_COUNT_MSB = 3;
    localparam int STAT_FULL      = 4;
    localparam int STAT_EMPTY     = 5;
    localparam int STAT_OVF       = 6;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Byte offset within the word is ignored: all accesses are word accesses.
    function automatic logic is_word(input logic [31:0] a, input logic [31:0] target);
        return a[31:2] == target[31:2];
    endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Processor data-bus plus TX stream handshake bundle.
interface data_bus_responder_if;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [31:0] OutData;
    logic        OutValid;
    logic        OutReady;

    modport master (
        output Addr, WriteData, MemWrite, OutReady,
        input  ReadData, OutData, OutValid
    );

    modport slave (
        input  Addr, WriteData, MemWrite, OutReady,
        output ReadData, OutData, OutValid
    );
endinterface

// File: rtl/word_fifo.sv
// Small synchronous FIFO with a combinational head word that reads 0 when
// empty. A push on full is accepted only if a pop happens in the same cycle.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointer and occupancy tracking; reset discards all queued words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Memory-mapped data-bus responder: word RAM, TX FIFO with STATUS register,
// and a free-running, loadable CYCLES counter. Loads are combinational.
module data_bus_responder
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    data_bus_responder_if.slave  bus
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              in_ram;
    logic              sel_tx;
    logic              sel_status;
    logic              sel_cycles;
    logic              tx_push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic [31:0]       cycles;
    logic [31:0]       status;
    logic [31:0]       rdata;

    assign ram_idx    = bus.Addr[RAM_AW+1:2];
    assign in_ram     = (bus.Addr < RAM_LIMIT) && ({2'b00, bus.Addr[31:2]} < 32'(RAM_WORDS));
    assign sel_tx     = is_word(bus.Addr, ADDR_TXDATA);
    assign sel_status = is_word(bus.Addr, ADDR_STATUS);
    assign sel_cycles = is_word(bus.Addr, ADDR_CYCLES);

    assign tx_push      = bus.MemWrite && sel_tx;
    assign pop          = !empty && bus.OutReady;
    assign bus.OutValid = !empty;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (tx_push),
        .wdata (bus.WriteData),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (bus.OutData)
    );

    // RAM store; contents survive reset.
    always_ff @(posedge Clk) begin
        if (bus.MemWrite && in_ram) ram[ram_idx] <= bus.WriteData;
    end

    // Sticky overflow: set on a dropped push, cleared by writing 1 to its STATUS bit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            overflow <= 1'b0;
        end else if (tx_push && full && !pop) begin
            overflow <= 1'b1;
        end else if (bus.MemWrite && sel_status && bus.WriteData[STAT_OVF]) begin
            overflow <= 1'b0;
        end
    end

    // Free-running cycle counter; a write loads it and counting resumes next cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycles <= '0;
        end else if (bus.MemWrite && sel_cycles) begin
            cycles <= bus.WriteData;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status                   = '0;
        status[STAT_COUNT_MSB:0] = 4'(fifo_count);
        status[STAT_FULL]        = full;
        status[STAT_EMPTY]       = empty;
        status[STAT_OVF]         = overflow;
    end

    // Zero-latency load mux; TXDATA and unmapped addresses read 0.
    always_comb begin
        rdata = '0;
        if (in_ram)          rdata = ram[ram_idx];
        else if (sel_status) rdata = status;
        else if (sel_cycles) rdata = cycles;
    end

    assign bus.ReadData = rdata;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder. Register reads are checked inline;
// TX words are scoreboarded: each accepted push queues its expected word and
// a monitor on the falling edge compares every pop against the queue front.
module tb_data_bus_responder;
    import mmio_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    data_bus_responder_if bus ();

    data_bus_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop monitor: a pop happens at the next rising edge when valid && ready.
    always @(negedge Clk) begin
        if (!Reset && bus.OutValid && bus.OutReady) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %h expected no pop", bus.OutData);
            end else begin
                check("pop_data", bus.OutData, exp_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.WriteData = d;
        bus.MemWrite = 1'b1;
        @(posedge Clk);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        exp_q.push_back(d);
        bus_write(ADDR_TXDATA, d);
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.Addr = a;
        #1;
        check(name, bus.ReadData, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drain();
        bus.OutReady = 1'b1;
        for (int i = 0; i < 20 && bus.OutValid; i++) begin
            @(posedge Clk);
            #1;
        end
        check("drain_done_outvalid", {31'b0, bus.OutValid}, 32'h0);
        bus.OutReady = 1'b0;
    endtask

    initial begin
        bus.Addr = '0;
        bus.WriteData = '0;
        bus.MemWrite = 1'b0;
        bus.OutReady = 1'b0;

        // Reset state
        @(posedge Clk);
        #1;
        check("rst_outvalid", {31'b0, bus.OutValid}, 32'h0);
        check("rst_outdata", bus.OutData, 32'h0);
        read_chk("rst_status", ADDR_STATUS, 32'h20);
        read_chk("rst_cycles", ADDR_CYCLES, 32'h0);
        Reset = 1'b0;
        read_chk("cycles_before_first_edge", ADDR_CYCLES, 32'h0);
        idle(1);
        read_chk("cycles_first_edge", ADDR_CYCLES, 32'h1);

        // RAM store and combinational load
        bus_write(32'h010, 32'hDEADBEEF);
        read_chk("ram_0x010", 32'h010, 32'hDEADBEEF);
        read_chk("ram_0x013", 32'h013, 32'hDEADBEEF);
        bus_write(32'h200, 32'h12345678);
        read_chk("unmapped_0x200", 32'h200, 32'h0);
        read_chk("txdata_read", ADDR_TXDATA, 32'h0);

        // FIFO push and drain; no bypass into an empty FIFO
        exp_q.push_back(32'h11);
        bus.Addr = ADDR_TXDATA;
        bus.WriteData = 32'h11;
        bus.MemWrite = 1'b1;
        #1;
        check("no_bypass_outvalid", {31'b0, bus.OutValid}, 32'h0);
        @(posedge Clk);
        #1;
        bus.MemWrite = 1'b0;
        check("outvalid_after_push", {31'b0, bus.OutValid}, 32'h1);
        push(32'h22);
        push(32'h33);
        push(32'h44);
        read_chk("full_status", ADDR_STATUS, 32'h14);
        check("full_outvalid", {31'b0, bus.OutValid}, 32'h1);
        check("full_outdata", bus.OutData, 32'h11);
        idle(2);
        check("stall_outdata_stable", bus.OutData, 32'h11);
        drain();
        read_chk("drained_status", ADDR_STATUS, 32'h20);
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

        // Overflow while full, then clear via STATUS write
        push(32'h11);
        push(32'h22);
        push(32'h33);
        push(32'h44);
        bus_write(ADDR_TXDATA, 32'h55);
        read_chk("overflow_status", ADDR_STATUS, 32'h54);
        bus_write(ADDR_STATUS, 32'h40);
        read_chk("overflow_cleared", ADDR_STATUS, 32'h14);

        // Push on full with a simultaneous pop
        bus.OutReady = 1'b1;
        push(32'h66);
        bus.OutReady = 1'b0;
        read_chk("push_pop_full_status", ADDR_STATUS, 32'h14);
        check("push_pop_full_head", bus.OutData, 32'h22);
        drain();
        check("overflow_queue_empty", 32'(exp_q.size()), 32'h0);

        // Simultaneous push and pop at count 1
        push(32'h77);
        bus.OutReady = 1'b1;
        push(32'h88);
        bus.OutReady = 1'b0;
        read_chk("push_pop_cnt1_status", ADDR_STATUS, 32'h01);
        check("push_pop_cnt1_head", bus.OutData, 32'h88);
        drain();

        // CYCLES load and wrap
        bus_write(ADDR_CYCLES, 32'hFFFFFFFE);
        read_chk("cycles_load", ADDR_CYCLES, 32'hFFFFFFFE);
        idle(1);
        read_chk("cycles_inc", ADDR_CYCLES, 32'hFFFFFFFF);
        idle(1);
        read_chk("cycles_wrap", ADDR_CYCLES, 32'h0);

        // Reset pulse between edges with words queued
        push(32'hA1);
        push(32'hA2);
        push(32'hA3);
        Reset = 1'b1;
        #1;
        check("midrst_outvalid", {31'b0, bus.OutValid}, 32'h0);
        check("midrst_outdata", bus.OutData, 32'h0);
        read_chk("midrst_status", ADDR_STATUS, 32'h20);
        exp_q.delete();
        Reset = 1'b0;
        read_chk("midrst_ram_kept", 32'h010, 32'hDEADBEEF);
        read_chk("midrst_cycles", ADDR_CYCLES, 32'h0);
        idle(1);
        read_chk("midrst_cycles_first_edge", ADDR_CYCLES, 32'h1);
        bus.OutReady = 1'b1;
        idle(2);
        bus.OutReady = 1'b0;
        read_chk("midrst_still_empty", ADDR_STATUS, 32'h20);

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameters SHALL be:
- RAM_WORDS, default 64, RAM depth in 32-bit words.
- FIFO_DEPTH, default 4, TX FIFO depth.
REQ-002 Ports SHALL be as below. The clock is Clk; the reset is Reset, asynchronous and active-high.
- Clk  in  1  clock
- Reset  in  1  asynchronous active-high reset
- Addr  in  32  processor data address (ALUResult)
- WriteData  in  32  processor store data
- MemWrite  in  1  store strobe, sampled on rising Clk
- ReadData  out  32  load data, combinational from Addr
- OutData  out  32  TX FIFO head word
- OutValid  out  1  TX FIFO non-empty
- OutReady  in  1  peripheral accepts head word

Function
REQ-003 Addr[1:0] SHALL be ignored; all accesses are word accesses.
REQ-004 Address map:
- 0x000-0x0FF: RAM, indexed by Addr[7:2].
- 0x400: TXDATA.
- 0x404: STATUS.
- 0x408: CYCLES.
- All other addresses read 0, and writes to them are ignored.
REQ-005 RAM write SHALL occur on rising Clk when MemWrite=1; RAM read SHALL be combinational (zero-cycle latency) so a single-cycle core sees data in the same cycle.
REQ-006 A TXDATA write SHALL push WriteData into the FIFO at rising Clk; a TXDATA read SHALL return 0.
REQ-007 STATUS read value:
- [3:0] = count.
- [4] = full.
- [5] = empty.
- [6] = overflow sticky.
- [31:7] = 0.
REQ-008 A STATUS write with WriteData[6]=1 SHALL clear overflow; the other STATUS bits are read-only.
REQ-009 CYCLES SHALL be a free-running 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0.
REQ-010 A CYCLES write SHALL load WriteData, and the counter SHALL increment from that value on the following cycle.
REQ-011 OutValid SHALL equal !empty, and OutData SHALL equal the head entry; a pop SHALL occur on rising Clk when OutValid && OutReady.
REQ-012 Push into an empty FIFO: there SHALL be no bypass, and OutValid SHALL rise the cycle after the store.
REQ-013 Push when full with no pop: the word SHALL be dropped, overflow SHALL set, and count SHALL stay FIFO_DEPTH.
REQ-014 Push when full with a simultaneous pop: the push SHALL be accepted, count SHALL stay FIFO_DEPTH, and no overflow SHALL be flagged.
REQ-015 Simultaneous push and pop at any other count SHALL leave count unchanged, with the write and read pointers both advancing.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL use log2(FIFO_DEPTH)+1 bits.
REQ-017 If OutValid=1 and OutReady=0, OutData SHALL remain stable until popped.

Reset
REQ-018 While Reset=1, the following SHALL hold immediately, independent of Clk:
- FIFO pointers and count = 0.
- OutValid = 0.
- overflow = 0.
- CYCLES = 0.
REQ-019 OutData SHALL read 0 while the FIFO is empty after reset.
REQ-020 RAM contents SHALL NOT be reset.
REQ-021 Reset asserted mid-transfer SHALL discard all FIFO contents; no pop SHALL be reported.
REQ-022 The first CYCLES increment SHALL occur on the first rising Clk after Reset deasserts.

Structure
REQ-023 Package mmio_pkg SHALL hold:
- Address constants ADDR_TXDATA, ADDR_STATUS, ADDR_CYCLES, RAM_LIMIT.
- STATUS bit-position constants.
- The default FIFO_DEPTH.
REQ-024 The FIFO SHALL be a sub-module word_fifo providing push/pop/full/empty/count/head; address decode, RAM and CYCLES stay in data_bus_responder.

Verification
REQ-025 RAM store and load: write 0xDEADBEEF to 0x010, then read 0x010 -> ReadData=0xDEADBEEF in the same cycle as Addr is applied; a read of 0x013 also returns 0xDEADBEEF.
REQ-026 FIFO push and drain:
- Stimulus: OutReady=0, push 0x11, 0x22, 0x33, 0x44.
- Before draining: STATUS=0x14, OutValid=1, OutData=0x11.
- Then assert OutReady -> OutData sequence 0x11, 0x22, 0x33, 0x44, ending with STATUS=0x20.
REQ-027 Overflow while full:
- With the FIFO full and OutReady=0, push 0x55 -> STATUS=0x54 and 0x55 never appears on OutData.
- Write STATUS with 0x40 -> STATUS=0x14.
REQ-028 Push on full with simultaneous pop: FIFO full, OutReady=1, push 0x66 -> 0x11 popped, count stays 4, no overflow, and 0x66 emerges fourth.
REQ-029 CYCLES load and wrap: write CYCLES with 0xFFFFFFFE -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 on successive cycles.
REQ-030 Reset mid-operation: with 3 words queued, pulse Reset between clock edges -> OutValid=0 and STATUS=0x20 immediately; a previously written RAM word is still readable.
